// File: rtl/sh_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sh_reg_ctrl
// Description : Round-robin two-port arbiter and job sequencer driving a
//               shared barrel shift register (load, N shift steps, capture).
// Revision    : 1.0 - initial release
// ============================================================================
module sh_reg_ctrl #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_dir,
    input  logic [SHW-1:0]   req0_amt,
    input  logic [CNTW-1:0]  req0_steps,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_dir,
    input  logic [SHW-1:0]   req1_amt,
    input  logic [CNTW-1:0]  req1_steps,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             sr_load,
    output logic             sr_shift_r_l,
    output logic [SHW-1:0]   sr_sh,
    output logic [WIDTH-1:0] sr_d_in,
    input  logic [WIDTH-1:0] sr_q,
    output logic             busy
);

    localparam logic [CNTW-1:0] c_cnt_one = CNTW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_CAPT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_gnt;
    logic              w_accept;
    logic [WIDTH-1:0]  r_data;
    logic              r_dir;
    logic [SHW-1:0]    r_amt;
    logic [CNTW-1:0]   r_steps;
    logic              r_id;
    logic              r_last_grant;
    logic [CNTW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_rsp_data;
    logic              r_rsp_id;

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            w_gnt = ~r_last_grant;
        end else begin
            w_gnt = req1_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        sr_load      = 1'b0;
        sr_shift_r_l = 1'b0;
        sr_sh        = '0;
        sr_d_in      = '0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (req0_valid || req1_valid) begin
                    w_accept   = 1'b1;
                    req0_ready = ~w_gnt;
                    req1_ready = w_gnt;
                    w_next     = S_LOAD;
                end
            end
            S_LOAD: begin
                sr_load = 1'b1;
                sr_d_in = r_data;
                w_next  = (r_steps != '0) ? S_SHIFT : S_CAPT;
            end
            S_SHIFT: begin
                sr_sh        = r_amt;
                sr_shift_r_l = r_dir;
                if (r_cnt == c_cnt_one) begin
                    w_next = S_CAPT;
                end
            end
            S_CAPT: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data       <= '0;
            r_dir        <= 1'b0;
            r_amt        <= '0;
            r_steps      <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data       <= w_gnt ? req1_data  : req0_data;
                r_dir        <= w_gnt ? req1_dir   : req0_dir;
                r_amt        <= w_gnt ? req1_amt   : req0_amt;
                r_steps      <= w_gnt ? req1_steps : req0_steps;
                r_id         <= w_gnt;
                r_last_grant <= w_gnt;
            end
            if (r_state == S_LOAD) begin
                r_cnt <= r_steps;
            end else if (r_state == S_SHIFT) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
            // Register output has settled after the last shift edge.
            if (r_state == S_CAPT) begin
                r_rsp_data <= sr_q;
                r_rsp_id   <= r_id;
            end
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_id   = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_sh_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sh_reg_ctrl
// Description : Directed self-checking bench for sh_reg_ctrl with a
//               behavioural barrel shift register attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sh_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic       req0_dir, req1_dir;
    logic [2:0] req0_amt, req1_amt;
    logic [3:0] req0_steps, req1_steps;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_data;
    logic       sr_load, sr_shift_r_l;
    logic [2:0] sr_sh;
    logic [7:0] sr_d_in;
    logic [7:0] r_sr_q;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Shared shift register the controller sequences.
    always_ff @(posedge clk) begin
        if (sr_load) begin
            r_sr_q <= sr_d_in;
        end else if (sr_sh != 3'd0) begin
            r_sr_q <= sr_shift_r_l ? (r_sr_q >> sr_sh) : (r_sr_q << sr_sh);
        end
    end

    sh_reg_ctrl #(.WIDTH(8), .SHW(3), .CNTW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_data    (req0_data),
        .req0_dir     (req0_dir),
        .req0_amt     (req0_amt),
        .req0_steps   (req0_steps),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_data    (req1_data),
        .req1_dir     (req1_dir),
        .req1_amt     (req1_amt),
        .req1_steps   (req1_steps),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .sr_load      (sr_load),
        .sr_shift_r_l (sr_shift_r_l),
        .sr_sh        (sr_sh),
        .sr_d_in      (sr_d_in),
        .sr_q         (r_sr_q),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit id, input bit v, input logic [7:0] d, input bit dir,
                           input logic [2:0] amt, input logic [3:0] steps);
        if (id) begin
            req1_valid = v; req1_data = d; req1_dir = dir; req1_amt = amt; req1_steps = steps;
        end else begin
            req0_valid = v; req0_data = d; req0_dir = dir; req0_amt = amt; req0_steps = steps;
        end
    endtask

    // Called in the cycle after the accept edge; returns cycles since accept.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},    busy,         0);
        chk({tag, "_rvalid"},  rsp_valid,    0);
        chk({tag, "_rdata"},   rsp_data,     0);
        chk({tag, "_rid"},     rsp_id,       0);
        chk({tag, "_rdy0"},    req0_ready,   0);
        chk({tag, "_rdy1"},    req1_ready,   0);
        chk({tag, "_load"},    sr_load,      0);
        chk({tag, "_sh"},      sr_sh,        0);
        chk({tag, "_dir"},     sr_shift_r_l, 0);
        chk({tag, "_din"},     sr_d_in,      0);
    endtask

    task automatic job(input string tag, input bit id, input logic [7:0] d, input bit dir,
                       input logic [2:0] amt, input logic [3:0] steps,
                       input logic [7:0] exp_d, input int exp_lat);
        int lat;
        set_req(id, 1'b1, d, dir, amt, steps);
        #1;
        chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
        step();
        set_req(id, 1'b0, d, dir, amt, steps);
        wait_rsp(lat);
        chk({tag, "_lat"},  lat,      exp_lat);
        chk({tag, "_data"}, rsp_data, exp_d);
        chk({tag, "_id"},   rsp_id,   id);
        step();
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int lat;
        bit seen;
        rst = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 0, 8'h00, 0, 3'd0, 4'd0);
        set_req(1, 0, 8'h00, 0, 3'd0, 4'd0);
        step();
        step();
        chk_reset_outputs("rst");
        rst = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);

        // Tie from reset: req0 first, then req1.
        set_req(0, 1, 8'h81, 0, 3'd1, 4'd1);
        set_req(1, 1, 8'h18, 1, 3'd1, 4'd1);
        #1;
        chk("arb0_rdy0", req0_ready, 1);
        chk("arb0_rdy1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        wait_rsp(lat);
        chk("arb0_id", rsp_id, 0);
        chk("arb0_data", rsp_data, 8'h02);
        chk("arb0_hold_rdy1", req1_ready, 0);
        step();
        chk("arb1_rdy1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        wait_rsp(lat);
        chk("arb1_id", rsp_id, 1);
        chk("arb1_data", rsp_data, 8'h0C);
        step();

        job("lone0", 0, 8'h01, 0, 3'd3, 4'd2, 8'h40, 5);

        // last grant was req0, so req1 wins this tie.
        set_req(0, 1, 8'h80, 1, 3'd7, 4'd1);
        set_req(1, 1, 8'h01, 0, 3'd7, 4'd1);
        #1;
        chk("arb2_rdy0", req0_ready, 0);
        chk("arb2_rdy1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        wait_rsp(lat);
        chk("arb2_id", rsp_id, 1);
        chk("arb2_data", rsp_data, 8'h80);
        step();
        chk("arb3_rdy0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        wait_rsp(lat);
        chk("arb3_id", rsp_id, 0);
        chk("arb3_data", rsp_data, 8'h01);
        step();

        job("left1",    0, 8'hAA, 0, 3'd1, 4'd1, 8'h54, 4);
        job("right3",   1, 8'hAA, 1, 3'd2, 4'd3, 8'h02, 6);
        job("zero_st",  0, 8'hEE, 0, 3'd3, 4'd0, 8'hEE, 3);
        job("zero_amt", 1, 8'hEE, 1, 3'd0, 4'd4, 8'hEE, 7);
        job("over",     0, 8'hFF, 0, 3'd4, 4'd3, 8'h00, 6);

        // Backpressure with a competing request parked on req1.
        rsp_ready = 1'b0;
        set_req(0, 1, 8'h0F, 0, 3'd1, 4'd2);
        step();
        req0_valid = 1'b0;
        wait_rsp(lat);
        chk("bp_lat", lat, 5);
        set_req(1, 1, 8'h81, 1, 3'd7, 4'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 8'h3C);
            chk("bp_id", rsp_id, 0);
            chk("bp_rdy0", req0_ready, 0);
            chk("bp_rdy1", req1_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_idle", busy, 0);
        chk("bp_rvalid", rsp_valid, 0);
        chk("bp_next_rdy1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        wait_rsp(lat);
        chk("bp_next_lat", lat, 4);
        chk("bp_next_data", rsp_data, 8'h01);
        chk("bp_next_id", rsp_id, 1);
        step();

        // Asynchronous reset in the second SHIFT cycle of a 5-step job.
        set_req(0, 1, 8'hFF, 0, 3'd1, 4'd5);
        step();
        req0_valid = 1'b0;
        chk("mid_load", sr_load, 1);
        chk("mid_din", sr_d_in, 8'hFF);
        step();
        chk("mid_sh", sr_sh, 1);
        chk("mid_sh_load", sr_load, 0);
        step();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        step();
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        chk("mid_no_rsp", seen, 0);
        job("fresh", 0, 8'h3C, 1, 3'd1, 4'd2, 8'h0F, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sh_reg_ctrl.md
# sh_reg_ctrl

Sequencing controller and two-port arbiter for the shared 8-bit barrel shift register (`load`, `shift_r_l`, `sh`, `d_in`, `d_out` ports).
- Accepts shift jobs from two requesters over valid/ready handshakes and grants one at a time, round-robin.
- Per job: loads the operand, applies the programmed number of shift steps, captures the result and returns it on a response channel tagged with the requester ID.

## Interface
- `WIDTH`, default 8: datapath width; matches the shift register.
- `SHW`, default 3: width of the per-step shift amount.
- `CNTW`, default 4: width of the step count; 0 to 15 steps per job.

- `clk`, input, 1: single clock, rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req0_valid` / `req1_valid`, input, 1: job offered by requester 0 / 1.
- `req0_ready` / `req1_ready`, output, 1: job accepted this cycle.
- `reqN_data`, input, WIDTH: operand.
- `reqN_dir`, input, 1: direction; 1 = right, 0 = left.
- `reqN_amt`, input, SHW: bits shifted per step.
- `reqN_steps`, input, CNTW: number of shift steps.
- `rsp_valid`, output, 1: result available.
- `rsp_ready`, input, 1: consumer accepts result.
- `rsp_id`, output, 1: requester that issued the job.
- `rsp_data`, output, WIDTH: final register contents.
- `sr_load`, output, 1: drives the shift register's load input.
- `sr_shift_r_l`, output, 1: drives the shift register's direction input.
- `sr_sh`, output, SHW: drives the shift register's shift amount.
- `sr_d_in`, output, WIDTH: drives the shift register's parallel input.
- `sr_q`, input, WIDTH: shift register's `d_out`.
- `busy`, output, 1: high in every state except IDLE.

## Operation
Shift register contract (same `clk`), applied on the rising edge:
- `load=1`: q <= d_in.
- `load=0`, `sh!=0`: shift by `sh` in direction `shift_r_l`, zero-fill.
- `load=0`, `sh=0`: hold.

FSM states: IDLE, LOAD, SHIFT, CAPT, RESP.
- **IDLE:**
  - Grant: if only one `valid` is high, grant it. If both are high, grant the requester other than `last_grant`.
  - Handshake: `reqN_ready` is combinational, high only for the granted requester in IDLE.
  - Latch on handshake: data, dir, amt, steps, id. `last_grant` <= id. Go to LOAD.
- **LOAD:** `sr_load=1`, `sr_d_in`=latched data, `sr_sh=0`. `cnt` <= steps. Go to SHIFT if steps != 0, else CAPT.
- **SHIFT:** `sr_load=0`, `sr_sh`=amt, `sr_shift_r_l`=dir. `cnt` decrements each cycle; on `cnt==1` go to CAPT. Amt = 0 is legal: the register holds.
- **CAPT:** `sr_load=0`, `sr_sh=0`. `rsp_data` <= `sr_q`, `rsp_id` <= id. Go to RESP.
- **RESP:** `rsp_valid=1`. On `rsp_ready`, go to IDLE.
  - `rsp_data` and `rsp_id` are held stable while `rsp_valid=1` and `rsp_ready=0`.
  - No new job is accepted until the response handshake completes.
- `sr_*` outputs outside LOAD/SHIFT: `sr_load=0`, `sr_sh=0`, `sr_shift_r_l=0`, `sr_d_in=0`.
- Requests arriving while busy are held off (`ready=0`). The requester must keep valid and payload stable until ready.

## Timing
- Reset values: state=IDLE, `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `busy=0`, `req*_ready=0`, `sr_load=0`, `sr_sh=0`, `sr_shift_r_l=0`, `sr_d_in=0`, `cnt=0`, `last_grant=1` (so req0 wins the first tie).
- Reset mid-job: controller returns to IDLE immediately (asynchronous). The in-flight job is dropped and no response is issued. Shift register contents are don't-care.
- Latency: with the accept handshake in cycle 0, `rsp_valid` rises in cycle S+3 for S steps.
  - Cycle 1: LOAD.
  - Cycles 2 to S+1: SHIFT.
  - Cycle S+2: CAPT.
- Minimum job-to-job spacing: S+4 cycles when `rsp_ready` is held high. The next accept occurs in the cycle after the response handshake.
- Simultaneous `rsp_ready` and a new `reqN_valid` in RESP: the response completes; the new request is accepted in the following IDLE cycle.
- Total shift per job is amt*steps; shifts of WIDTH bits or more yield 0.

## Test plan
- Single left job: req0, data=10101010, dir=0, amt=1, steps=1 -> `rsp_data`=01010100, `rsp_id`=0, `rsp_valid` 4 cycles after accept.
- Multi-step right job: req1, data=10101010, dir=1, amt=2, steps=3 -> `rsp_data`=00000010, `rsp_id`=1, latency 6 cycles.
- Zero steps, and amt=0 with steps=4: data=11101110 -> `rsp_data`=11101110 in both cases, latencies 3 and 7 cycles.
- Arbitration: both valid from reset with distinct data -> req0 served first, then req1. Both valid again -> req1 first (alternates). A lone requester is always granted.
- Backpressure: `rsp_ready=0` for 5 cycles -> `rsp_valid`, `rsp_data`, `rsp_id` stable, both ready signals 0; `rsp_ready=1` -> IDLE next cycle.
- Reset mid-SHIFT: assert `rst` in the 2nd SHIFT cycle of a steps=5 job -> all outputs at reset values immediately, no response. A fresh job after deassert completes correctly.
